// File: rtl/dma_bank_decode.sv
// DMA address decoder / bank selector: latches the bus address on a dbapr rise and
// holds range, bank and write decode through a hold window. Optional sticky range error via DMA_DECODE_AERR_EN.
module dma_bank_decode #(
  parameter int ADDR_W    = 24,
  parameter int MEM_LOG2  = 22,
  parameter int BANK_LSB  = 20,
  parameter int BANK_W    = 2,
  parameter int NUM_BANKS = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic                 sysclk,
  input  logic                 sys_rst_n,
  input  logic                 dbapr,
  input  logic [ADDR_W-1:0]    bd_n,
  input  logic                 bmem_n,
  input  logic                 binput_n,
  input  logic                 moff_n,
  input  logic                 bgnt_n,
  input  logic                 err_clr,
  output logic                 aok,
  output logic [NUM_BANKS-1:0] bank,
  output logic                 mwrite_n,
  output logic                 ddbapr_n,
  output logic                 busy,
  output logic                 aerr
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic                  dbapr_q;
  logic                  arm_q;
  logic [3:0]            cnt_q, cnt_d;
  logic                  aok_q, aok_d;
  logic [NUM_BANKS-1:0]  bank_q, bank_d;
  logic                  mwr_q, mwr_d;
  logic                  busy_q, busy_d;

  logic [ADDR_W-1:0]     addr_in;
  logic [BANK_W-1:0]     idx_in;
  logic                  mem_in, rd_in, off_in;
  logic                  in_range;
  logic [NUM_BANKS-1:0]  bank_raw;
  logic                  rise, fall, latch;

  function automatic logic [NUM_BANKS-1:0] onehot_f(input logic [BANK_W-1:0] idx);
    logic [NUM_BANKS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_BANKS; i++) oh[i] = (int'(idx) == i);
    return oh;
  endfunction

  assign addr_in = ~bd_n;
  assign idx_in  = addr_in[BANK_LSB +: BANK_W];
  assign mem_in  = ~bmem_n;
  assign rd_in   = ~binput_n;
  assign off_in  = ~moff_n;

  assign in_range = mem_in & ~off_in & (addr_in[ADDR_W-1:MEM_LOG2] == '0) &
                    (int'(idx_in) < NUM_BANKS);
  assign bank_raw = in_range ? onehot_f(idx_in) : '0;

  // The first clock after reset only primes the strobe history, so a strobe
  // already high at release is never mistaken for a rise.
  assign rise = dbapr & ~dbapr_q & arm_q;
  assign fall = ~dbapr & dbapr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aok_d   = aok_q;
    bank_d  = bank_q;
    mwr_d   = mwr_q;
    latch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) latch = 1'b1;
      end
      S_ACTIVE: begin
        if (fall) begin
          if (HOLD_CYC == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            cnt_d   = 4'(HOLD_CYC);
          end
        end
      end
      S_HOLD: begin
        if (rise) begin
          latch = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (latch) begin
      state_d = S_ACTIVE;
      cnt_d   = '0;
      aok_d   = in_range;
      bank_d  = bank_raw;
      mwr_d   = in_range & ~rd_in;
    end else if (state_d == S_IDLE) begin
      aok_d  = 1'b0;
      bank_d = '0;
      mwr_d  = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      dbapr_q <= 1'b0;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      aok_q   <= 1'b0;
      bank_q  <= '0;
      mwr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dbapr_q <= dbapr;
      arm_q   <= 1'b1;
      cnt_q   <= cnt_d;
      aok_q   <= aok_d;
      bank_q  <= bank_d;
      mwr_q   <= mwr_d;
      busy_q  <= busy_d;
    end
  end

  // Grant gates only the bank strobes and the write; aok stays visible.
  assign aok      = aok_q;
  assign bank     = bank_q & {NUM_BANKS{~bgnt_n}};
  assign mwrite_n = ~(mwr_q & ~bgnt_n);
  assign ddbapr_n = ~dbapr_q;
  assign busy     = busy_q;

`ifdef DMA_DECODE_AERR_EN
  logic aerr_q, aerr_d;

  always_comb begin
    aerr_d = aerr_q;
    if (err_clr) aerr_d = 1'b0;
    if (latch && mem_in && !off_in && !in_range) aerr_d = 1'b1;
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) aerr_q <= 1'b0;
    else            aerr_q <= aerr_d;
  end

  assign aerr = aerr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign aerr = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^addr_in;

endmodule
